// File: rtl/mul_shift_add.sv
// Unsigned shift-and-add multiplier, BIT_COUNT x BIT_COUNT -> 2*BIT_COUNT.
// Start/busy/done handshake; one multiplier bit is consumed per RUN cycle.
// Optional: define MUL_SHIFT_ADD_EARLY_EXIT_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (product is unchanged).

module adder #(
  parameter int BIT_COUNT = 8
) (
  input  logic [BIT_COUNT-1:0] a,
  input  logic [BIT_COUNT-1:0] b,
  input  logic                 cin,
  output logic [BIT_COUNT-1:0] sum,
  output logic                 cout
);
  // Plain ripple add; carry out is the top bit of the widened sum
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BIT_COUNT{1'b0}}, cin};
endmodule

module mul_shift_add #(
  parameter int BIT_COUNT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [BIT_COUNT-1:0]   a,
  input  logic [BIT_COUNT-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [2*BIT_COUNT-1:0] product
);
  localparam int W2 = 2 * BIT_COUNT;
  localparam int CW = $clog2(BIT_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_COUNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [W2-1:0]    mcand, acc, addend, sum;
  logic [BIT_COUNT-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic             unused_cout;

  // Partial product: shifted multiplicand gated by the current multiplier bit
  assign addend = mplier[0] ? mcand : '0;

  adder #(.BIT_COUNT(W2)) u_add (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (unused_cout)   // product always fits in W2 bits
  );

`ifdef MUL_SHIFT_ADD_EARLY_EXIT_EN
  // Stop once no set multiplier bits remain after this cycle's shift
  assign last = (cnt == CNT_LAST) || (mplier[BIT_COUNT-1:1] == '0);
`else
  assign last = (cnt == CNT_LAST);
`endif

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        accept    = 1'b1;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        state_nxt = start ? RUN : IDLE;
        accept    = start;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      if (accept) begin
        mcand  <= {{BIT_COUNT{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      // Final sum goes straight to the product on entry to DONE
      if (state == RUN && last) product <= sum;
    end
  end
endmodule
